leaf_out_arbiter: RTL and testbench

Round-robin arbiter that shares one leaf_interface user output port (32-bit payload, vld/ack stream) among several user operators inside a leaf. It sits between the operator outputs and `din_leaf_user2interface`/`vld_user2interface`/`ack_interface2user`. Pages that pack more than one operator into a leaf can then use a single interface output port. Grants are burst-granular with a bounded burst length. The output is a single registered stage that carries the source index.

---
 rtl/leaf_out_arbiter.sv | 143 ++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-granular arbiter that merges several operator output streams into one
// leaf interface output port through a single registered stage tagged with the source index.
module leaf_out_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned REQ_BITS     = 2,
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned BURST_MAX    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
    input  logic [NUM_REQ-1:0]              vld_req,
    output logic [NUM_REQ-1:0]              ack_req,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic                            vld_out,
    input  logic                            ack_out,
    output logic [REQ_BITS-1:0]             src_out,
    output logic                            busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                  state_q, state_d;
    logic [REQ_BITS-1:0]     g_q, g_d;
    logic [REQ_BITS-1:0]     last_q, last_d;
    logic [REQ_BITS-1:0]     src_q, src_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] dout_q, dout_d;
    logic                    vld_q, vld_d;

    logic                    vld_g;
    logic [PAYLOAD_BITS-1:0] din_g;
    logic                    grant_ack;
    logic                    xfer;
    logic [REQ_BITS-1:0]     pick;
    logic                    pick_vld;

    // Two ascending passes give the scan order last+1, last+2, ... modulo NUM_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_vld && vld_req[j] && (REQ_BITS'(j) > last_q)) begin
                pick_vld = 1'b1;
                pick     = REQ_BITS'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_vld && vld_req[j] && (REQ_BITS'(j) <= last_q)) begin
                pick_vld = 1'b1;
                pick     = REQ_BITS'(j);
            end
        end
    end

    always_comb begin
        vld_g = 1'b0;
        din_g = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (g_q == REQ_BITS'(j)) begin
                vld_g = vld_req[j];
                din_g = din_req[j*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // The grant's accept depends only on state and the output stage, never on vld_req.
    assign grant_ack = !vld_q || ack_out;
    assign xfer      = (state_q == StGrant) && vld_g && grant_ack;

    always_comb begin
        ack_req = '0;
        if (state_q == StGrant) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (g_q == REQ_BITS'(j)) begin
                    ack_req[j] = grant_ack;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (en && pick_vld) begin
                    g_d     = pick;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!vld_g) begin
                    state_d = StIdle;
                    last_d  = g_q;
                end else if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(BURST_MAX - 1)) begin
                        state_d = StIdle;
                        last_d  = g_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vld_d  = xfer || (vld_q && !ack_out);
        dout_d = xfer ? din_g : dout_q;
        src_d  = xfer ? g_q : src_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            g_q     <= '0;
            last_q  <= REQ_BITS'(NUM_REQ - 1);
            cnt_q   <= '0;
            dout_q  <= '0;
            src_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            src_q   <= src_d;
            vld_q   <= vld_d;
        end
    end

    assign dout    = dout_q;
    assign src_out = src_q;
    assign vld_out = vld_q;
    assign busy    = (state_q == StGrant) || vld_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter (4 requesters, bursts of 4) with per-source scoreboard.
module tb_leaf_out_arbiter;

    localparam int unsigned NReq  = 4;
    localparam int unsigned Pw    = 32;
    localparam int unsigned Burst = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic [NReq*Pw-1:0]   din_req;
    logic [NReq-1:0]      vld_req;
    logic [NReq-1:0]      ack_req;
    logic [Pw-1:0]        dout;
    logic                 vld_out;
    logic                 ack_out;
    logic [1:0]           src_out;
    logic                 busy;

    leaf_out_arbiter #(
        .NUM_REQ     (NReq),
        .REQ_BITS    (2),
        .PAYLOAD_BITS(Pw),
        .BURST_MAX   (Burst)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .din_req(din_req),
        .vld_req(vld_req),
        .ack_req(ack_req),
        .dout   (dout),
        .vld_out(vld_out),
        .ack_out(ack_out),
        .src_out(src_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] srcq [NReq][$];
    logic [31:0] expq [NReq][$];
    logic [NReq-1:0] pend_in;
    int unsigned out_src_log[$];
    logic [31:0] out_dat_log[$];
    int unsigned del_cnt [NReq];
    int unsigned gap_cnt;
    logic [31:0] gen [NReq][64];
    int unsigned rr_exp [20] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NReq; i++) begin
            vld_req[i]          = (srcq[i].size() > 0);
            din_req[i*Pw +: Pw] = (srcq[i].size() > 0) ? srcq[i][0] : 32'h0;
        end
    endtask

    task automatic clear_logs();
        out_src_log.delete();
        out_dat_log.delete();
        gap_cnt = 0;
        for (int i = 0; i < NReq; i++) del_cnt[i] = 0;
    endtask

    task automatic flush();
        for (int i = 0; i < NReq; i++) begin
            srcq[i].delete();
            expq[i].delete();
        end
        pend_in = '0;
        vld_req = '0;
        din_req = '0;
    endtask

    // One clock: drive requesters, observe handshakes mid-cycle, then advance past the edge.
    task automatic tick();
        logic has_word;
        drive_reqs();
        #1;
        for (int i = 0; i < NReq; i++) pend_in[i] = vld_req[i] & ack_req[i];
        if (out_src_log.size() > 0 && !vld_out) gap_cnt++;
        if (vld_out && ack_out) begin
            has_word = (expq[src_out].size() > 0);
            check_eq("sb_has_word", 64'(has_word), 64'd1);
            if (has_word) check_eq("sb_data", 64'(dout), 64'(expq[src_out].pop_front()));
            out_src_log.push_back(32'(src_out));
            out_dat_log.push_back(dout);
            del_cnt[src_out]++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NReq; i++) begin
            if (pend_in[i]) expq[i].push_back(srcq[i].pop_front());
        end
        pend_in = '0;
    endtask

    function automatic bit pending();
        bit p = vld_out;
        for (int i = 0; i < NReq; i++) begin
            if (srcq[i].size() > 0 || expq[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input bit rand_ack);
        int unsigned n = 0;
        while (pending() && n < 2000) begin
            ack_out = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        ack_out = 1'b1;
        check_eq("drain_done", 64'(n < 2000), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        ack_out = 1'b1;
        pend_in = '0;
        vld_req = '0;
        din_req = '0;
        clear_logs();
        #1;
        check_eq("rst_dout", 64'(dout), 64'h0);
        check_eq("rst_vld_out", 64'(vld_out), 64'h0);
        check_eq("rst_ack_req", 64'(ack_req), 64'h0);
        check_eq("rst_src_out", 64'(src_out), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Park a word in the output stage, then reset asynchronously mid-cycle.
        ack_out = 1'b0;
        srcq[1].push_back(32'h11);
        tick();
        tick();
        check_eq("inflight_vld", 64'(vld_out), 64'h1);
        check_eq("inflight_dout", 64'(dout), 64'h11);
        check_eq("inflight_src", 64'(src_out), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_vld_out", 64'(vld_out), 64'h0);
        check_eq("async_dout", 64'(dout), 64'h0);
        check_eq("async_src_out", 64'(src_out), 64'h0);
        check_eq("async_ack_req", 64'(ack_req), 64'h0);
        check_eq("async_busy", 64'(busy), 64'h0);
        flush();
        #2;
        reset   = 1'b0;
        ack_out = 1'b1;

        // Round robin with all four continuously valid.
        clear_logs();
        for (int i = 0; i < NReq; i++) begin
            for (int k = 0; k < 8; k++) srcq[i].push_back(32'h100 * (i + 1) + k);
        end
        tick();
        check_eq("first_grant", 64'(ack_req), 64'b0001);
        begin
            int unsigned n = 0;
            while (out_src_log.size() < 20 && n < 200) begin
                tick();
                n++;
            end
            check_eq("rr_done", 64'(n < 200), 64'd1);
        end
        for (int k = 0; k < 20; k++) begin
            if (k < out_src_log.size()) check_eq("rr_src", 64'(out_src_log[k]), 64'(rr_exp[k]));
        end
        check_eq("rr_gaps", 64'(gap_cnt), 64'd4);
        drain(1'b0);

        // Voluntary release: requester 2 sends three words, requester 1 waits.
        clear_logs();
        for (int k = 0; k < 3; k++) srcq[2].push_back(32'hA0 + k);
        tick();
        srcq[1].push_back(32'hB0);
        srcq[1].push_back(32'hB1);
        drain(1'b0);
        check_eq("rel_count", 64'(out_src_log.size()), 64'd5);
        if (out_src_log.size() == 5) begin
            check_eq("rel_src0", 64'(out_src_log[0]), 64'd2);
            check_eq("rel_src2", 64'(out_src_log[2]), 64'd2);
            check_eq("rel_src3", 64'(out_src_log[3]), 64'd1);
            check_eq("rel_dat2", 64'(out_dat_log[2]), 64'hA2);
            check_eq("rel_dat3", 64'(out_dat_log[3]), 64'hB0);
            check_eq("rel_dat4", 64'(out_dat_log[4]), 64'hB1);
        end

        // Backpressure: 64 random words per requester, a 5-cycle stall in the first burst.
        clear_logs();
        for (int i = 0; i < NReq; i++) begin
            for (int k = 0; k < 64; k++) begin
                gen[i][k] = $urandom;
                srcq[i].push_back(gen[i][k]);
            end
        end
        tick();
        tick();
        tick();
        ack_out = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("bp_dout", 64'(dout), 64'(gen[2][1]));
            check_eq("bp_src", 64'(src_out), 64'd2);
            check_eq("bp_ack_req", 64'(ack_req), 64'h0);
        end
        ack_out = 1'b1;
        drain(1'b1);
        if (out_src_log.size() > 4) begin
            check_eq("bp_burst_w3", 64'(out_src_log[3]), 64'd2);
            check_eq("bp_next_src", 64'(out_src_log[4]), 64'd3);
        end
        for (int i = 0; i < NReq; i++) check_eq("bp_delivered", 64'(del_cnt[i]), 64'd64);

        // Enable dropped during word 2 of a burst.
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) srcq[0].push_back(32'hD0 + k);
        srcq[1].push_back(32'hE0);
        srcq[1].push_back(32'hE1);
        srcq[3].push_back(32'hF0);
        tick();
        tick();
        tick();
        en = 1'b0;
        repeat (10) tick();
        check_eq("en_words", 64'(out_src_log.size()), 64'd4);
        if (out_dat_log.size() == 4) check_eq("en_last_word", 64'(out_dat_log[3]), 64'hD3);
        check_eq("en_busy", 64'(busy), 64'h0);
        check_eq("en_ack_req", 64'(ack_req), 64'h0);
        check_eq("en_held", 64'(srcq[1].size()), 64'd2);
        en = 1'b1;
        drain(1'b0);
        check_eq("en_total", 64'(out_src_log.size()), 64'd7);
        if (out_src_log.size() == 7) begin
            check_eq("en_resume_src", 64'(out_src_log[4]), 64'd1);
            check_eq("en_tail_src", 64'(out_src_log[6]), 64'd3);
        end

        // Skip idle requesters and wrap.
        do_reset();
        srcq[0].push_back(32'h55);
        drain(1'b0);
        clear_logs();
        srcq[3].push_back(32'h33);
        tick();
        check_eq("skip_grant3", 64'(ack_req), 64'b1000);
        check_eq("skip_busy", 64'(busy), 64'h1);
        drain(1'b0);
        srcq[1].push_back(32'h77);
        tick();
        check_eq("wrap_grant1", 64'(ack_req), 64'b0010);
        drain(1'b0);
        check_eq("skip_count", 64'(out_src_log.size()), 64'd2);
        if (out_src_log.size() == 2) begin
            check_eq("skip_src0", 64'(out_src_log[0]), 64'd3);
            check_eq("skip_src1", 64'(out_src_log[1]), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
